// File: rtl/rf_access_pkg.sv
// Shared types for the reflection variable access port: FSM states,
// latched request and registered response records.
package rf_access_pkg;

  // Struct field widths; the top level's DATA_W/ID_W defaults track these.
  localparam int RF_DATA_W = 32;
  localparam int RF_ID_W   = 4;
  localparam int RF_BE_W   = RF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } rf_state_e;

  typedef struct packed {
    logic                 write;
    logic [RF_ID_W-1:0]   id;
    logic [RF_DATA_W-1:0] data;
    logic [RF_BE_W-1:0]   be;
  } rf_req_t;

  typedef struct packed {
    logic [RF_DATA_W-1:0] data;
    logic                 err;
    logic                 dirty;
  } rf_rsp_t;

endpackage

// File: rtl/rf_var_bank.sv
// Variable storage with dirty tracking, byte-enable merge for host writes,
// hardware-update priority on collisions and flattened var_q view.
module rf_var_bank #(
  parameter int NUM_VARS = 16,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_en,
  input  logic                       acc_write,
  input  logic [ID_W-1:0]            acc_id,
  input  logic [DATA_W-1:0]          acc_data,
  input  logic [DATA_W/8-1:0]        acc_be,
  input  logic                       hw_we,
  input  logic [ID_W-1:0]            hw_id,
  input  logic [DATA_W-1:0]          hw_data,
  output logic [DATA_W-1:0]          acc_rdata,
  output logic                       acc_err,
  output logic                       acc_dirty,
  output logic [NUM_VARS*DATA_W-1:0] var_q
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ID_W:0] NUM_VARS_L = (ID_W+1)'(NUM_VARS);

  logic [DATA_W-1:0] vars  [NUM_VARS];
  logic              dirty [NUM_VARS];

  logic              in_range;
  logic [DATA_W-1:0] old_val;
  logic              old_dirty;
  logic [DATA_W-1:0] merged;

  assign in_range = ({1'b0, acc_id} < NUM_VARS_L);

  always_comb begin
    old_val   = '0;
    old_dirty = 1'b0;
    if (in_range) begin
      old_val   = vars[acc_id];
      old_dirty = dirty[acc_id];
    end
  end

  always_comb begin
    merged = old_val;
    for (int b = 0; b < BE_W; b++) begin
      if (acc_be[b]) merged[b*8 +: 8] = acc_data[b*8 +: 8];
    end
  end

  // A write response reports the host-merged word even if a hardware
  // update lands on the same variable in this cycle.
  always_comb begin
    acc_err   = ~in_range;
    acc_dirty = old_dirty;
    acc_rdata = '0;
    if (in_range) acc_rdata = acc_write ? merged : old_val;
  end

  for (genvar i = 0; i < NUM_VARS; i++) begin : g_var
    logic hw_hit;
    logic acc_hit;

    assign hw_hit  = hw_we  && (hw_id  == ID_W'(i));
    assign acc_hit = acc_en && (acc_id == ID_W'(i));

    // Hardware update takes priority over the host access for storage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vars[i]  <= '0;
        dirty[i] <= 1'b0;
      end else if (hw_hit) begin
        vars[i]  <= hw_data;
        dirty[i] <= 1'b1;
      end else if (acc_hit) begin
        if (acc_write) vars[i] <= merged;
        dirty[i] <= 1'b0;
      end
    end

    assign var_q[i*DATA_W +: DATA_W] = vars[i];
  end

endmodule

// File: rtl/rf_var_access_port.sv
// Reflection-layer get/set port: request latch, three-state FSM and
// registered response in front of the variable bank.
module rf_var_access_port
  import rf_access_pkg::*;
#(
  parameter int NUM_VARS = 16,
  parameter int DATA_W   = RF_DATA_W,
  parameter int ID_W     = RF_ID_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ID_W-1:0]            req_id,
  input  logic [DATA_W-1:0]          req_data,
  input  logic [DATA_W/8-1:0]        req_be,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic                       rsp_err,
  output logic                       rsp_dirty,
  input  logic                       hw_we,
  input  logic [ID_W-1:0]            hw_id,
  input  logic [DATA_W-1:0]          hw_data,
  output logic [NUM_VARS*DATA_W-1:0] var_q
);

  rf_state_e state;
  rf_state_e state_next;
  rf_req_t   req_q;
  rf_rsp_t   rsp_q;

  logic [DATA_W-1:0] bank_rdata;
  logic              bank_err;
  logic              bank_dirty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (req_valid) state_next = EXEC;
      EXEC: state_next = RESP;
      RESP: if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= '0;
    end else if (state == IDLE && req_valid) begin
      req_q <= '{write: req_write, id: req_id, data: req_data, be: req_be};
    end
  end

  // Response is captured once in EXEC and held until the host consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
    end else if (state == EXEC) begin
      rsp_q <= '{data: bank_rdata, err: bank_err, dirty: bank_dirty};
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;
  assign rsp_dirty = rsp_q.dirty;

  rf_var_bank #(
    .NUM_VARS (NUM_VARS),
    .DATA_W   (DATA_W),
    .ID_W     (ID_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .acc_en    (state == EXEC),
    .acc_write (req_q.write),
    .acc_id    (req_q.id),
    .acc_data  (req_q.data),
    .acc_be    (req_q.be),
    .hw_we     (hw_we),
    .hw_id     (hw_id),
    .hw_data   (hw_data),
    .acc_rdata (bank_rdata),
    .acc_err   (bank_err),
    .acc_dirty (bank_dirty),
    .var_q     (var_q)
  );

endmodule

// File: tb/tb_rf_var_access_port.sv
// Self-checking bench for rf_var_access_port with a behavioural variable model.
module tb_rf_var_access_port;

  localparam int NV = 12;
  localparam int DW = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [IW-1:0] req_id;
  logic [DW-1:0] req_data;
  logic [3:0]    req_be;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_dirty;
  logic          hw_we;
  logic [IW-1:0] hw_id;
  logic [DW-1:0] hw_data;
  logic [NV*DW-1:0] var_q;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem  [16];
  logic        dirt [16];

  rf_var_access_port #(.NUM_VARS(NV), .DATA_W(DW), .ID_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_id(req_id), .req_data(req_data), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_dirty(rsp_dirty),
    .hw_we(hw_we), .hw_id(hw_id), .hw_data(hw_data),
    .var_q(var_q)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      mem[i]  = '0;
      dirt[i] = 1'b0;
    end
  endtask

  task automatic model_hw(input logic [3:0] id, input logic [31:0] d);
    if (int'(id) < NV) begin
      mem[id]  = d;
      dirt[id] = 1'b1;
    end
  endtask

  task automatic model_request(input logic wr, input logic [3:0] id, input logic [31:0] d,
                               input logic [3:0] be, input logic col, input logic [31:0] hv,
                               output logic [31:0] ed, output logic ee, output logic edy);
    logic [31:0] m;
    if (int'(id) >= NV) begin
      ed = '0; ee = 1'b1; edy = 1'b0;
    end else begin
      m   = (d & be_mask(be)) | (mem[id] & ~be_mask(be));
      ed  = wr ? m : mem[id];
      ee  = 1'b0;
      edy = dirt[id];
      if (wr) mem[id] = m;
      dirt[id] = 1'b0;
      if (col) model_hw(id, hv);
    end
  endtask

  task automatic check_vars(input string name);
    for (int i = 0; i < NV; i++) begin
      checks++;
      if (var_q[i*DW +: DW] !== mem[i]) begin
        errors++;
        $display("[TB] FAIL %s var_q[%0d] got %h want %h", name, i, var_q[i*DW +: DW], mem[i]);
      end
    end
  endtask

  task automatic hw_update(input logic [3:0] id, input logic [31:0] d);
    @(negedge clk);
    hw_we = 1'b1; hw_id = id; hw_data = d;
    model_hw(id, d);
    @(negedge clk);
    hw_we = 1'b0;
  endtask

  task automatic run_req(input logic wr, input logic [3:0] id, input logic [31:0] d,
                         input logic [3:0] be, input logic col, input logic [31:0] hv,
                         input string name);
    logic [31:0] ed;
    logic ee, edy;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s req_ready_idle got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_write = wr; req_id = id; req_data = d; req_be = be;
    model_request(wr, id, d, be, col, hv, ed, ee, edy);
    @(negedge clk);
    req_valid = 1'b0; req_data = $urandom; req_id = 4'($urandom); req_be = 4'($urandom);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL %s exec_phase valid=%b ready=%b want 0/0", name, rsp_valid, req_ready);
    end
    if (col) begin
      hw_we = 1'b1; hw_id = id; hw_data = hv;
    end
    @(negedge clk);
    hw_we = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL %s rsp_valid_latency got %b want 1", name, rsp_valid);
    end
    checks++;
    if (rsp_data !== ed) begin
      errors++; $display("[TB] FAIL %s rsp_data got %h want %h", name, rsp_data, ed);
    end
    checks++;
    if (rsp_err !== ee) begin
      errors++; $display("[TB] FAIL %s rsp_err got %b want %b", name, rsp_err, ee);
    end
    checks++;
    if (rsp_dirty !== edy) begin
      errors++; $display("[TB] FAIL %s rsp_dirty got %b want %b", name, rsp_dirty, edy);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL %s consumed valid=%b ready=%b want 0/1", name, rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    model_clear();
    checks++;
    if ({rsp_valid, rsp_err, rsp_dirty} !== 3'b000 || rsp_data !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_rsp got v=%b e=%b d=%b data=%h want 0", rsp_valid, rsp_err, rsp_dirty, rsp_data);
    end
    check_vars("reset_vars");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_get_basic();
    run_req(1'b0, 4'd3, 32'hFFFF_FFFF, 4'hF, 1'b0, '0, "get_id3");
  endtask

  task automatic test_set_be();
    run_req(1'b1, 4'd5, 32'hDEAD_BEEF, 4'b0011, 1'b0, '0, "set_id5_be");
    checks++;
    if (var_q[5*DW +: DW] !== 32'h0000_BEEF) begin
      errors++; $display("[TB] FAIL set_be_var5 got %h want 0000beef", var_q[5*DW +: DW]);
    end
    run_req(1'b1, 4'd5, 32'h1122_3344, 4'b1100, 1'b0, '0, "set_id5_hi");
  endtask

  task automatic test_hw_dirty();
    hw_update(4'd2, 32'h1234_5678);
    run_req(1'b0, 4'd2, '0, 4'h0, 1'b0, '0, "hw_get1");
    run_req(1'b0, 4'd2, '0, 4'h0, 1'b0, '0, "hw_get2");
  endtask

  task automatic test_out_of_range();
    hw_update(4'd14, 32'hCAFE_F00D);
    run_req(1'b0, 4'd13, '0, 4'h0, 1'b0, '0, "oor_get13");
    run_req(1'b1, 4'd12, 32'h5555_5555, 4'hF, 1'b0, '0, "oor_set12");
    check_vars("oor_vars");
  endtask

  task automatic test_collision();
    run_req(1'b1, 4'd7, 32'h1122_3344, 4'hF, 1'b0, '0, "col_prep");
    run_req(1'b0, 4'd7, '0, 4'h0, 1'b1, 32'hA5A5_A5A5, "col_get7");
    checks++;
    if (var_q[7*DW +: DW] !== 32'hA5A5_A5A5) begin
      errors++; $display("[TB] FAIL col_store7 got %h want a5a5a5a5", var_q[7*DW +: DW]);
    end
    run_req(1'b0, 4'd7, '0, 4'h0, 1'b0, '0, "col_reget7");
    run_req(1'b1, 4'd8, 32'h0BAD_CAFE, 4'b0101, 1'b1, 32'h7777_0000, "col_set8");
    check_vars("col_vars");
  endtask

  task automatic test_backpressure();
    logic [31:0] ed;
    logic ee, edy;
    hw_update(4'd9, 32'h0F0F_1234);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_id = 4'd9; req_be = 4'h0;
    model_request(1'b0, 4'd9, '0, 4'h0, 1'b0, '0, ed, ee, edy);
    @(negedge clk);
    req_valid = 1'b1; req_id = 4'd1;
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== ed ||
          rsp_err !== ee || rsp_dirty !== edy) begin
        errors++;
        $display("[TB] FAIL hold_%0d got v=%b r=%b data=%h e=%b d=%b want 1/0/%h/%b/%b",
                 k, rsp_valid, req_ready, rsp_data, rsp_err, rsp_dirty, ed, ee, edy);
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release ready=%b valid=%b want 1/0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ed;
    logic ee, edy;
    logic [3:0] ids [3] = '{4'd2, 4'd5, 4'd11};
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
        errors++; $display("[TB] FAIL b2b_ready_%0d got %b want 1", k, req_ready);
      end
      req_valid = 1'b1; req_write = k[0]; req_id = ids[k]; req_data = 32'h0101_0101 * (k + 1);
      req_be = 4'hF;
      model_request(k[0], ids[k], 32'h0101_0101 * (k + 1), 4'hF, 1'b0, '0, ed, ee, edy);
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("[TB] FAIL b2b_exec_%0d ready got %b want 0", k, req_ready);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== ed || rsp_dirty !== edy) begin
        errors++;
        $display("[TB] FAIL b2b_rsp_%0d got v=%b data=%h d=%b want 1/%h/%b", k, rsp_valid, rsp_data, rsp_dirty, ed, edy);
      end
    end
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check_vars("b2b_vars");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        hw_update(4'($urandom_range(0, 15)), $urandom);
      end else begin
        run_req(1'($urandom), 4'($urandom_range(0, 15)), $urandom, 4'($urandom),
                ($urandom_range(0, 3) == 0), $urandom, $sformatf("rand_%0d", n));
      end
      if (n % 10 == 9) check_vars($sformatf("rand_vars_%0d", n));
    end
  endtask

  task automatic test_reset_in_resp();
    hw_update(4'd4, 32'h4444_4444);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_id = 4'd4; req_data = 32'h9999_9999; req_be = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_clear();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0) begin
      errors++; $display("[TB] FAIL rst_in_resp valid=%b data=%h want 0/0", rsp_valid, rsp_data);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL rst_release_ready got %b want 1", req_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL rst_no_rsp_%0d got %b want 0", k, rsp_valid);
      end
    end
    check_vars("rst_vars");
    run_req(1'b0, 4'd4, '0, 4'h0, 1'b0, '0, "post_rst_get4");
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_id = '0; req_data = '0; req_be = '0;
    rsp_ready = 1'b0;
    hw_we = 1'b0; hw_id = '0; hw_data = '0;
    model_clear();
    test_reset();
    test_get_basic();
    test_set_be();
    test_hw_dirty();
    test_out_of_range();
    test_collision();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_in_resp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
